// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants, FSM state encoding and hex-to-segment
//               table for the four-digit seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Everything dark: segments and digit enables are both active-low
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SA_OFF  = 4'b1111;

    // Scan FSM state: DRIVE lights one digit, DEAD is the anti-ghosting gap
    typedef logic [0:0] state_t;
    localparam state_t ST_DRIVE = 1'b0;
    localparam state_t ST_DEAD  = 1'b1;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Purely combinational hex nibble to active-low seven-segment
//               pattern lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup; the caller registers the result
    always_comb begin
        seg = SEG_TABLE[hex];
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Four-digit multiplexed seven-segment scanner with dead-time
//               gaps and frame-synchronous, tear-free double buffering of the
//               displayed value.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_CYC = 50000,
    parameter int unsigned DEAD_CYC  = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic        ready,
    output logic        frame,
    output logic [7:0]  led,
    output logic [3:0]  sa
);

    localparam int          c_IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [19:0] c_DRIVE_LAST = 20'(DIGIT_CYC - 1);
    localparam logic [19:0] c_DEAD_LAST  = 20'(DEAD_CYC - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    // Scan sequencing
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [19:0]          r_cnt;
    logic [19:0]          w_cnt_nxt;
    logic                 w_last;
    logic                 w_boundary;

    // Write buffering
    logic                 r_pending;
    logic [15:0]          r_pend_data;
    logic [3:0]           r_pend_dp;
    logic [3:0]           r_pend_blank;
    logic [15:0]          r_disp_data;
    logic [3:0]           r_disp_dp;
    logic [3:0]           r_disp_blank;
    logic                 w_accept;
    logic                 w_commit;

    // Output path: the registers load from the values that will be in effect
    // next cycle, so SA/LED line up exactly with the FSM state
    logic [15:0]          w_data_nxt;
    logic [3:0]           w_dp_nxt;
    logic [3:0]           w_blank_nxt;
    logic [3:0]           w_nib;
    logic [6:0]           w_seg;
    logic [7:0]           r_led;
    logic [3:0]           r_sa;

    // Next-state logic: dwell counter runs per state, index advances leaving DEAD
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 20'd1;
        w_last      = (r_state == ST_DRIVE) ? (r_cnt == c_DRIVE_LAST)
                                            : (r_cnt == c_DEAD_LAST);
        if (w_last) begin
            w_cnt_nxt = '0;
            if (r_state == ST_DRIVE) begin
                w_state_nxt = ST_DEAD;
            end else begin
                w_state_nxt = ST_DRIVE;
                w_idx_nxt   = r_idx + c_IDX_ONE;
            end
        end
    end

    // Frame boundary is the final DEAD cycle after the last digit
    assign w_boundary = (r_state == ST_DEAD) && (r_idx == c_IDX_LAST) && w_last;
    assign w_commit   = w_boundary && r_pending;
    assign w_accept   = wr_en && !r_pending;

    // Scan FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DEAD;
            r_idx   <= c_IDX_LAST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pending buffer capture and frame-boundary commit to the display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_disp_data  <= 16'h0000;
            r_disp_dp    <= 4'b0000;
            r_disp_blank <= 4'b1111;
        end else if (w_commit) begin
            r_pending    <= 1'b0;
            r_disp_data  <= r_pend_data;
            r_disp_dp    <= r_pend_dp;
            r_disp_blank <= r_pend_blank;
        end else if (w_accept) begin
            r_pending    <= 1'b1;
            r_pend_data  <= wr_data;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_in;
        end
    end

    // Display contents that will be visible in the cycle after this edge
    always_comb begin
        w_data_nxt  = w_commit ? r_pend_data  : r_disp_data;
        w_dp_nxt    = w_commit ? r_pend_dp    : r_disp_dp;
        w_blank_nxt = w_commit ? r_pend_blank : r_disp_blank;
        w_nib       = w_data_nxt[{w_idx_nxt, 2'b00} +: 4];
    end

    seg7_hex_decode u_hex_decode (
        .hex (w_nib),
        .seg (w_seg)
    );

    // Registered digit enable and segment outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa  <= SA_OFF;
            r_led <= SEG_OFF;
        end else if (w_state_nxt == ST_DRIVE) begin
            r_sa  <= ~(4'b0001 << w_idx_nxt);
            r_led <= w_blank_nxt[w_idx_nxt] ? SEG_OFF : {w_seg, ~w_dp_nxt[w_idx_nxt]};
        end else begin
            r_sa  <= SA_OFF;
            r_led <= SEG_OFF;
        end
    end

    assign sa    = r_sa;
    assign led   = r_led;
    assign ready = ~r_pending;
    assign frame = w_boundary;

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGIT_CYC, default 50000: clock cycles each digit is driven per scan slot (legal range 2 to 2^20-1).
REQ-002 Parameter DEAD_CYC, default 500: clock cycles of all-off anti-ghosting gap after each digit (legal range 1 to 2^16-1).
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 WR_EN  input  1  write strobe; accepted only while READY=1.
REQ-006 WR_DATA  input  16  four hex digits; nibble k ([4k+3:4k]) maps to digit k.
REQ-007 DP_IN  input  4  decimal point request per digit, 1 = lit.
REQ-008 BLANK_IN  input  4  per-digit blank request, 1 = digit dark.
REQ-009 READY  output  1  1 = no write pending, a new write is accepted.
REQ-010 FRAME  output  1  one-cycle pulse at every frame boundary.
REQ-011 LED  output  8  segments {a,b,c,d,e,f,g,dp}, active-low.
REQ-012 SA  output  4  digit enables, active-low, at most one bit low.

Function
REQ-013 The FSM SHALL have two states: DRIVE (one digit enabled) and DEAD (SA=4'b1111, LED=8'hFF).
REQ-014 DRIVE SHALL last exactly DIGIT_CYC cycles, then go to DEAD; DEAD SHALL last exactly DEAD_CYC cycles, then go to DRIVE with the digit index incremented mod 4 (3 wraps to 0).
REQ-015 In DRIVE for index k, SA[k] SHALL be 0, all other SA bits 1, and LED SHALL be registered, with no combinational path from any input.
REQ-016 LED[7:1] in DRIVE SHALL be the active-low hex code of the active nibble: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-017 LED[0] SHALL be 0 when the active digit's committed DP bit is 1, and 1 otherwise.
REQ-018 A digit whose committed BLANK bit is 1 SHALL output LED=8'hFF, with SA still scanning as normal.
REQ-019 A write (WR_EN=1, READY=1) SHALL capture WR_DATA, DP_IN and BLANK_IN into a pending buffer and drive READY=0 on the next cycle.
REQ-020 WR_EN while READY=0 SHALL be ignored; the pending buffer SHALL be unchanged.
REQ-021 A frame boundary is the last cycle of DEAD for index 3; on it, a pending buffer SHALL be copied to the display registers and READY SHALL return to 1 on the next cycle.
REQ-022 The display SHALL never change mid-frame, so no tearing occurs.
REQ-023 A write accepted on the frame-boundary cycle itself SHALL be committed at the following boundary, not the current one.
REQ-024 FRAME SHALL pulse high for one cycle coincident with every frame boundary, whether or not a commit occurs.
REQ-025 One frame SHALL last exactly 4*(DIGIT_CYC+DEAD_CYC) cycles.

Reset
REQ-026 When RST=1 at a clock edge, the block SHALL enter DEAD with index 3, and both the dwell counter and the pending flag SHALL clear.
REQ-027 Reset SHALL set display data to 16'h0000, DP to 4'b0000 and BLANK to 4'b1111, and SHALL discard the pending buffer.
REQ-028 Outputs after reset SHALL be SA=4'b1111, LED=8'hFF, READY=1 and FRAME=0.
REQ-029 The first FRAME pulse after reset SHALL occur DEAD_CYC cycles after RST deasserts, and digit 0 SHALL drive next.
REQ-030 Reset asserted mid-write or mid-frame SHALL abort immediately, with no partial commit.

Structure
REQ-031 Shared package seg7_pkg SHALL hold NUM_DIGITS=4, SEG_OFF=8'hFF, SA_OFF=4'b1111, the FSM state typedef and the 16-entry segment table constants.
REQ-032 Hex-to-segment conversion SHALL live in one combinational sub-module, seg7_hex_decode (4-bit in, 7-bit active-low out); the scan controller registers its output.

Verification
Benches SHALL use DIGIT_CYC=4 and DEAD_CYC=2, giving a 24-cycle frame.
REQ-033 Reset release: FRAME pulses at cycle 2 after RST deasserts; SA=1110 for cycles 3-6; LED=FF throughout because all digits are blanked.
REQ-034 Write 16'h3210, DP=0001, BLANK=0000: READY=0 until the next FRAME; then each digit shows for 4 cycles: digit0 LED=00000010, digit1 LED=10011111, digit2 LED=00100101, digit3 LED=00001101.
REQ-035 Second WR_EN while READY=0, data 16'hFFFF: it is ignored, and after commit digit0 still shows 0.
REQ-036 WR_EN on the FRAME cycle: the commit is deferred exactly 24 cycles, and READY stays 0 for that period.
REQ-037 BLANK=0100 with data 16'h8888: digit2 slot shows LED=FF with SA=1011; the other digits show 00000001.
REQ-038 RST pulsed during a DRIVE of digit 1 with a write pending: next cycle SA=1111, LED=FF, READY=1, and the pending data is never displayed.
